dsi_lanes_arbiter: RTL
======================

Name: dsi_lanes_arbiter

Overview:
Packet-level arbiter and lane distributor feeding the 4 lane FIFOs of the DSI lanes controller.
Shares the lanes between two requesters: a command source (req 0, LP or HS packets) and a video source (req 1, HS only).
Spreads each accepted beat's bytes across lanes 0..cnt-1 in the 33-bit lane-FIFO word format.
Enforces a drain-plus-gap interval between packets so every lane returns to LP-11 between packets.

Parameters:
GAP_W, 8, width of inter-packet gap counter
DEFAULT_GAP, 8'd4, gap cycles used when cfg_gap_cycles is 0

Ports:
clk_sys  in  1  system clock; also drives the lane-FIFO write side, so it must equal data_fifo_write_clk
rst_n  in  1  asynchronous active-low reset
cfg_lanes_number  in  2  active lanes minus 1 (0..3)
cfg_gap_cycles  in  GAP_W  idle cycles after drain; 0 selects DEFAULT_GAP
lines_ready  in  1  LP buffers on; from lanes controller
clock_ready  in  1  HS clock running; from lanes controller
cmd_valid / vid_valid  in  1  beat valid per requester
cmd_ready / vid_ready  out  1  beat accepted when valid&ready
cmd_data / vid_data  in  32  byte k, bits 8k+7:8k, goes to lane k
cmd_cnt / vid_cnt  in  3  valid bytes in beat, 1..4
cmd_last / vid_last  in  1  final beat of packet
cmd_lp  in  1  packet is LP; sampled on first beat
fifo_data  out  33  {lane3, lane2, lane1, lpm, lane0}
fifo_write  out  4  per-lane write strobe
fifo_full  in  4  per-lane full
fifo_empty  in  4  per-lane empty (write-side)
busy  out  1  state != IDLE
err_cnt  out  1  sticky; set on illegal cnt, cleared by reset only

Behaviour:
- Reset: state IDLE, all ready = 0, fifo_write = 0, fifo_data = 0, busy = 0, err_cnt = 0, rr pointer = cmd.
- States: IDLE -> XFER -> DRAIN -> GAP -> IDLE.
- IDLE, eligibility:
  - cmd is eligible when cmd_valid & (cmd_lp ? lines_ready : clock_ready).
  - vid is eligible when vid_valid & clock_ready.
- IDLE, grant:
  - Round-robin. The rr pointer names the favoured requester.
  - If only one requester is eligible, grant it.
  - Grant registers at the clock edge, then enter XFER. No beat is accepted in the IDLE cycle.
  - The LP flag is latched at grant, from cmd_lp (vid is always 0).
- XFER:
  - Effective count eff = min(cnt, cfg_lanes_number+1). If lp, eff = 1.
  - mask = lanes 0..eff-1.
  - ready_granted = ~|(fifo_full & mask). This is combinational, with zero-cycle write latency.
  - On accept: fifo_write = mask, fifo_data carries granted data with bit 8 = lp, and unused lanes are 0.
  - On accept with last: go to DRAIN, and flip rr to the non-granted requester.
- Illegal cnt: 0, or > lanes+1, or >1 when lp.
  - Set err_cnt.
  - cnt 0 writes nothing but still accepts the beat; otherwise the beat is truncated to eff.
- The non-granted requester's ready stays 0 for the whole packet. Packets are atomic.
- DRAIN: wait until &(fifo_empty | ~enabled_lanes), where enabled = lanes 0..cfg_lanes_number. Then load the gap counter and go to GAP.
- GAP: count down cfg_gap_cycles (or DEFAULT_GAP) cycles, then go to IDLE. Minimum 1.
- Readiness lost mid-packet: losing clock_ready or lines_ready does not abort the packet. The next grant waits until readiness returns.
- Changing cfg_lanes_number: takes effect only at grant. The value is latched at the IDLE -> XFER transition.
- Reset mid-packet: immediate return to reset values. FIFO contents are the lanes controller's responsibility.

Optional Feature:
Macro DSI_ARB_STATS_EN.
- When defined, adds these outputs, all reset to 0, wrapping at 2^16, no saturation:
  - stat_cmd_pkts (16): increments on a cmd last-beat accept.
  - stat_vid_pkts (16): increments on a vid last-beat accept.
  - stat_stall_cycles (16): increments in XFER while the granted valid=1 and ready=0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- 4 lanes, vid packet of 3 beats, cnt 4,4,2, FIFOs never full -> writes 4'b1111, 4'b1111, 4'b0011; bit8 = 0; then DRAIN, gap of 4 cycles, busy low.
- cmd_lp = 1, cnt 1, clock_ready = 0, lines_ready = 1 -> granted; fifo_write = 4'b0001, fifo_data[8] = 1.
- Both valid continuously, 1-beat packets -> grants alternate cmd, vid, cmd, vid; never two grants without an intervening DRAIN+GAP.
- 2 lanes (cfg = 1), fifo_full[1] asserted for 5 cycles mid-packet -> vid_ready = 0 for exactly those 5 cycles; no write strobe is issued; the beat is then accepted unchanged.
- cfg = 0, vid_cnt = 3 -> err_cnt = 1, fifo_write = 4'b0001, lane 0 byte only.
- Reset asserted during XFER -> next cycle all outputs at reset values; after release the first grant goes to cmd.

Source files
------------

// File: rtl/dsi_lanes_arbiter.sv
// ============================================================================
// Module      : dsi_lanes_arbiter
// Description : Packet arbiter and lane distributor for the four DSI lane
//               FIFOs. Two requesters are served round-robin:
//               - cmd (requester 0) carries LP or HS packets.
//               - vid (requester 1) carries HS packets only.
//               Each accepted beat is spread over lanes 0..eff-1 in the
//               33-bit lane word {lane3, lane2, lane1, lpm, lane0}.
//               After each packet the arbiter waits for the enabled lanes to
//               drain, then holds an idle gap, so every lane returns to LP-11
//               between packets.
// Ports       : clk_sys, rst_n       clock, async active-low reset
//               cfg_lanes_number     active lanes minus 1 (latched at grant)
//               cfg_gap_cycles       post-drain idle cycles (0 -> DEFAULT_GAP)
//               lines_ready          LP readiness from the lanes controller
//               clock_ready          HS readiness from the lanes controller
//               cmd_* / vid_*        valid/ready beat streams
//               fifo_data            lane-FIFO write word
//               fifo_write           per-lane write strobes
//               fifo_full            per-lane full flags
//               fifo_empty           per-lane empty flags
//               busy                 arbiter not idle
//               err_cnt              sticky illegal-count flag
// Options     : DSI_ARB_STATS_EN adds the stat_* packet/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_lanes_arbiter #(
    parameter int               GAP_W       = 8,
    parameter logic [GAP_W-1:0] DEFAULT_GAP = 8'd4
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic [1:0]       cfg_lanes_number,
    input  logic [GAP_W-1:0] cfg_gap_cycles,
    input  logic             lines_ready,
    input  logic             clock_ready,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_data,
    input  logic [2:0]       cmd_cnt,
    input  logic             cmd_last,
    input  logic             cmd_lp,
    input  logic             vid_valid,
    output logic             vid_ready,
    input  logic [31:0]      vid_data,
    input  logic [2:0]       vid_cnt,
    input  logic             vid_last,
    output logic [32:0]      fifo_data,
    output logic [3:0]       fifo_write,
    input  logic [3:0]       fifo_full,
    input  logic [3:0]       fifo_empty,
    output logic             busy,
    output logic             err_cnt
`ifdef DSI_ARB_STATS_EN
    ,
    output logic [15:0]      stat_cmd_pkts,
    output logic [15:0]      stat_vid_pkts,
    output logic [15:0]      stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [GAP_W-1:0] c_gap_one = GAP_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_gnt;      // 0 = cmd owns the lanes, 1 = vid
    logic             r_rr;       // favoured requester when both are eligible
    logic             r_lp;
    logic [1:0]       r_lanes;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_err;

    logic             w_cmd_elig;
    logic             w_vid_elig;
    logic             w_any_elig;
    logic             w_pick_vid;
    logic             w_g_valid;
    logic [31:0]      w_g_data;
    logic [2:0]       w_g_cnt;
    logic             w_g_last;
    logic [2:0]       w_lanes_p1;
    logic [2:0]       w_eff;
    logic [3:0]       w_mask;
    logic [3:0]       w_en_mask;
    logic             w_illegal;
    logic             w_lane_ready;
    logic             w_xfer;
    logic             w_accept;
    logic             w_drained;
    logic [GAP_W-1:0] w_gap_load;
    logic [7:0]       w_b0, w_b1, w_b2, w_b3;

    // ------------------------------------------------------------------
    // Eligibility and round-robin pick (only used in IDLE)
    // ------------------------------------------------------------------
    assign w_cmd_elig = cmd_valid & (cmd_lp ? lines_ready : clock_ready);
    assign w_vid_elig = vid_valid & clock_ready;
    assign w_any_elig = w_cmd_elig | w_vid_elig;
    assign w_pick_vid = (w_cmd_elig & w_vid_elig) ? r_rr : w_vid_elig;

    // ------------------------------------------------------------------
    // Granted-stream mux and lane mask
    // ------------------------------------------------------------------
    assign w_g_valid  = r_gnt ? vid_valid : cmd_valid;
    assign w_g_data   = r_gnt ? vid_data  : cmd_data;
    assign w_g_cnt    = r_gnt ? vid_cnt   : cmd_cnt;
    assign w_g_last   = r_gnt ? vid_last  : cmd_last;
    assign w_lanes_p1 = {1'b0, r_lanes} + 3'd1;

    // A zero count writes nothing; LP packets only ever use lane 0.
    always_comb begin
        w_eff = w_g_cnt;
        if (w_g_cnt == 3'd0)
            w_eff = 3'd0;
        else if (r_lp)
            w_eff = 3'd1;
        else if (w_g_cnt > w_lanes_p1)
            w_eff = w_lanes_p1;
    end

    always_comb begin
        case (w_eff)
            3'd0:    w_mask = 4'b0000;
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            3'd3:    w_mask = 4'b0111;
            default: w_mask = 4'b1111;
        endcase
    end

    always_comb begin
        case (r_lanes)
            2'd0:    w_en_mask = 4'b0001;
            2'd1:    w_en_mask = 4'b0011;
            2'd2:    w_en_mask = 4'b0111;
            default: w_en_mask = 4'b1111;
        endcase
    end

    assign w_illegal    = (w_g_cnt == 3'd0) || (w_g_cnt > w_lanes_p1) ||
                          (r_lp && (w_g_cnt > 3'd1));
    assign w_lane_ready = ~|(fifo_full & w_mask);
    assign w_xfer       = (r_state == S_XFER);
    assign w_accept     = w_xfer & w_g_valid & w_lane_ready;
    assign w_drained    = &(fifo_empty | ~w_en_mask);
    assign w_gap_load   = (cfg_gap_cycles == '0) ? DEFAULT_GAP : cfg_gap_cycles;

    assign w_b0 = w_mask[0] ? w_g_data[7:0]   : 8'h00;
    assign w_b1 = w_mask[1] ? w_g_data[15:8]  : 8'h00;
    assign w_b2 = w_mask[2] ? w_g_data[23:16] : 8'h00;
    assign w_b3 = w_mask[3] ? w_g_data[31:24] : 8'h00;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs (zero-latency write path)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        vid_ready   = 1'b0;
        fifo_write  = 4'b0000;
        fifo_data   = 33'd0;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig)
                    w_state_nxt = S_XFER;
            end
            S_XFER: begin
                cmd_ready = ~r_gnt & w_lane_ready;
                vid_ready =  r_gnt & w_lane_ready;
                if (w_accept && (w_mask != 4'b0000)) begin
                    fifo_write = w_mask;
                    fifo_data  = {w_b3, w_b2, w_b1, r_lp, w_b0};
                end
                if (w_accept && w_g_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drained)
                    w_state_nxt = S_GAP;
            end
            default: begin
                // Counter <= 1 also covers a zero gap, giving at least one cycle.
                if (r_gap_cnt <= c_gap_one)
                    w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, round-robin, gap counter and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= 1'b0;
            r_rr      <= 1'b0;
            r_lp      <= 1'b0;
            r_lanes   <= 2'd0;
            r_gap_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_any_elig) begin
                r_gnt   <= w_pick_vid;
                r_lp    <= ~w_pick_vid & cmd_lp;
                r_lanes <= cfg_lanes_number;
            end
            if (w_accept && w_g_last)
                r_rr <= ~r_gnt;
            if (w_accept && w_illegal)
                r_err <= 1'b1;
            if ((r_state == S_DRAIN) && w_drained)
                r_gap_cnt <= w_gap_load;
            else if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt - c_gap_one;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign err_cnt = r_err;

`ifdef DSI_ARB_STATS_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmd_pkts     <= 16'd0;
            stat_vid_pkts     <= 16'd0;
            stat_stall_cycles <= 16'd0;
        end else begin
            if (w_accept && w_g_last && !r_gnt)
                stat_cmd_pkts <= stat_cmd_pkts + 16'd1;
            if (w_accept && w_g_last && r_gnt)
                stat_vid_pkts <= stat_vid_pkts + 16'd1;
            if (w_xfer && w_g_valid && !w_lane_ready)
                stat_stall_cycles <= stat_stall_cycles + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
